// File: rtl/rom_pixel_fetcher.sv
// rom_pixel_fetcher: walks the image ROM word by word and unpacks each 32-bit
// word into four 8-bit grayscale pixels on a valid/ready stream with (x, y).
// ROM read latency is absorbed by a per-word wait in FETCH before capture.
module rom_pixel_fetcher #(
    parameter int unsigned IMG_W    = 160,
    parameter int unsigned IMG_H    = 120,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              restart,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [7:0]        pix_data,
    output logic [7:0]        pix_x,
    output logic [6:0]        pix_y,
    output logic              pix_last,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned WORDS = IMG_W * IMG_H / 4;
    localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [LAT_W-1:0]  LatLast  = LAT_W'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(WORDS - 1);
    localparam logic [7:0]        XLast    = 8'(IMG_W - 1);
    localparam logic [6:0]        YLast    = 7'(IMG_H - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StUnpack,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;

    // Next-state logic: restart overrides everything, including a pending start.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        lat_d   = lat_q;
        word_d  = word_q;
        idx_d   = idx_q;

        if (restart) begin
            state_d = StIdle;
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
            lat_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StFetch;
                        addr_d  = '0;
                        x_d     = '0;
                        y_d     = '0;
                        lat_d   = '0;
                    end
                end
                StFetch: begin
                    // rom_addr has been stable READ_LAT cycles at this edge
                    if (lat_q == LatLast) begin
                        word_d  = rom_data;
                        idx_d   = '0;
                        state_d = StUnpack;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                StUnpack: begin
                    if (pix_ready) begin
                        idx_d = idx_q + 2'd1;
                        if (x_q == XLast) begin
                            x_d = '0;
                            y_d = y_q + 7'd1;
                        end else begin
                            x_d = x_q + 8'd1;
                        end
                        if (idx_q == 2'd3) begin
                            if (addr_q == AddrLast) begin
                                state_d = StDone;
                                x_d     = '0;
                                y_d     = '0;
                            end else begin
                                addr_d  = addr_q + ADDR_W'(1);
                                lat_d   = '0;
                                state_d = StFetch;
                            end
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    x_d     = '0;
                    y_d     = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers; reset discards any word in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            lat_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lat_q   <= lat_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decode registered state only, so pix_ready never reaches pix_valid.
    always_comb begin
        pix_valid = (state_q == StUnpack);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        rom_addr  = addr_q;
        pix_x     = x_q;
        pix_y     = y_q;
        pix_last  = pix_valid && (x_q == XLast) && (y_q == YLast);
        pix_data  = pix_valid ? word_q[{idx_q, 3'b000} +: 8] : 8'd0;
    end

endmodule

// File: tb/tb_rom_pixel_fetcher.sv
// Scoreboard bench for rom_pixel_fetcher: three instances (default image at
// READ_LAT=2, small images at READ_LAT=1 and 4) run one at a time.
module tb_rom_pixel_fetcher;

    function automatic int w_of(input int g);
        return (g == 0) ? 160 : (g == 1) ? 8 : 12;
    endfunction
    function automatic int h_of(input int g);
        return (g == 0) ? 120 : (g == 1) ? 4 : 3;
    endfunction
    function automatic int l_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 4;
    endfunction

    typedef struct packed {
        logic [1:0]  g;
        logic [14:0] addr;
        logic        last;
        logic [6:0]  y;
        logic [7:0]  x;
        logic [7:0]  d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        st   [3];
    logic        rs   [3];
    logic        rdy  [3];
    logic [14:0] ra   [3];
    logic [31:0] rd   [3];
    logic [7:0]  pd   [3];
    logic [7:0]  px   [3];
    logic [6:0]  py   [3];
    logic        pl   [3];
    logic        pv   [3];
    logic        bsy  [3];
    logic        dn   [3];

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #20 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = w_of(g);
        localparam int unsigned H = h_of(g);
        localparam int unsigned L = l_of(g);

        logic [14:0] pipe [4];
        logic [14:0] src;
        logic [31:0] n4;

        // ROM model: a word only becomes visible READ_LAT cycles after its address
        always @(posedge clk) begin
            pipe[0] <= ra[g];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        if (L == 1) begin : g_comb
            assign src = ra[g];
        end else begin : g_pipe
            assign src = pipe[L-2];
        end
        assign n4    = 32'(src) * 32'd4;
        assign rd[g] = {n4[7:0] + 8'd3, n4[7:0] + 8'd2, n4[7:0] + 8'd1, n4[7:0]};

        rom_pixel_fetcher #(
            .IMG_W   (W),
            .IMG_H   (H),
            .READ_LAT(L),
            .ADDR_W  (15)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (st[g]),
            .restart  (rs[g]),
            .rom_addr (ra[g]),
            .rom_data (rd[g]),
            .pix_data (pd[g]),
            .pix_x    (px[g]),
            .pix_y    (py[g]),
            .pix_last (pl[g]),
            .pix_valid(pv[g]),
            .pix_ready(rdy[g]),
            .busy     (bsy[g]),
            .done     (dn[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on every handshake, and check outputs hold during stalls.
    logic [31:0] prev_out   [3];
    logic        prev_stall [3];
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (reset === 1'b1) begin
                if (prev_stall[g] === 1'b1)
                    chk("stall_hold", {8'd0, pv[g], pl[g], py[g], px[g], pd[g]}, prev_out[g]);
                if (pv[g] && rdy[g]) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_pixel: inst %0d got x=%0d y=%0d, expected none",
                                 g, px[g], py[g]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("pix_inst", 32'(g), 32'(e.g));
                        chk("pix_fields", {8'd0, pl[g], py[g], px[g], pd[g]},
                            {8'd0, e.last, e.y, e.x, e.d});
                        chk("pix_addr", 32'(ra[g]), 32'(e.addr));
                    end
                end
                prev_stall[g] <= pv[g] && !rdy[g] && !rs[g];
                prev_out[g]   <= {8'd0, pv[g], pl[g], py[g], px[g], pd[g]};
            end else begin
                prev_stall[g] <= 1'b0;
            end
        end
    end

    // Push the whole frame in raster order, then pulse start (returns at E0+1).
    task automatic start_frame(input int g, input bit bp);
        int w, n;
        exp_t e;
        w = w_of(g);
        n = w * h_of(g);
        @(posedge clk);
        #1;
        for (int p = 0; p < n; p++) begin
            e.g    = 2'(g);
            e.addr = 15'(p / 4);
            e.last = (p == n - 1);
            e.y    = 7'(p / w);
            e.x    = 8'(p % w);
            e.d    = 8'(p);
            exp_q.push_back(e);
        end
        st[g]  = 1'b1;
        rdy[g] = 1'b0;
        @(posedge clk);
        #1;
        st[g]  = 1'b0;
        rdy[g] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic run_frame(input int g, input bit bp);
        int words, lat, nom, max_k, done_cnt, done_k;
        bit fin;
        words    = w_of(g) * h_of(g) / 4;
        lat      = l_of(g);
        nom      = words * (lat + 4);
        max_k    = bp ? nom * 3 + 100 : nom + 100;
        done_cnt = 0;
        done_k   = -1;
        fin      = 1'b0;
        start_frame(g, bp);
        for (int k = 1; k <= max_k && !fin; k++) begin
            @(posedge clk);
            #1;
            st[g]  = (k < nom - 10) && (k % 97 == 50);
            rdy[g] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (k == lat) chk("first_valid", 32'(pv[g]), 32'd1);
            if (k == lat - 1) chk("no_early_valid", 32'(pv[g]), 32'd0);
            if (dn[g]) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 2) fin = 1'b1;
        end
        st[g]  = 1'b0;
        rdy[g] = 1'b0;
        chk("done_pulses", 32'(done_cnt), 32'd1);
        if (!bp) chk("done_cycle", 32'(done_k), 32'(nom));
        chk("busy_after_done", 32'(bsy[g]), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit found;
        reset = 1'b0;
        for (int g = 0; g < 3; g++) begin
            st[g]  = 1'b0;
            rs[g]  = 1'b0;
            rdy[g] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(pv[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_done", 32'(dn[0]), 32'd0);
        chk("rst_addr", 32'(ra[0]), 32'd0);
        chk("rst_pix", {8'd0, pl[0], py[0], px[0], pd[0]}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(bsy[0]), 32'd0);
        chk("idle_addr", 32'(ra[0]), 32'd0);
        chk("idle_valid", 32'(pv[0]), 32'd0);

        // Restart while unpacking word 100 under backpressure
        start_frame(0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 5000 && !found; k++) begin
            @(posedge clk);
            #1;
            if (ra[0] == 15'd100 && pv[0]) begin
                rs[0]  = 1'b1;
                rdy[0] = 1'b0;
                found  = 1'b1;
            end else begin
                rdy[0] = 1'($urandom_range(0, 1));
            end
        end
        chk("reach_word100", 32'(found), 32'd1);
        @(posedge clk);
        #1 rs[0] = 1'b0;
        @(negedge clk);
        chk("restart_valid", 32'(pv[0]), 32'd0);
        chk("restart_busy", 32'(bsy[0]), 32'd0);
        chk("restart_addr", 32'(ra[0]), 32'd0);
        chk("restart_xy", {17'd0, py[0], px[0]}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("restart_no_done", 32'(dn[0]), 32'd0);
        end
        exp_q.delete();

        // Full frames on the default instance, then latency variants
        run_frame(0, 1'b0);
        run_frame(0, 1'b1);
        run_frame(1, 1'b1);
        run_frame(1, 1'b0);
        run_frame(2, 1'b1);
        run_frame(2, 1'b0);

        // Reset in the middle of a fetch: nothing left behind, no done
        start_frame(2, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bsy[2]), 32'd0);
        chk("midrst_valid", 32'(pv[2]), 32'd0);
        chk("midrst_addr", 32'(ra[2]), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(dn[2]), 32'd0);
        end
        exp_q.delete();
        run_frame(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
